cache_miss_ctrl: RTL and testbench

- Per-access control FSM for the set-associative data cache.
- Consumes hit/dirty/victim-tag results from the way-select/replacement stage.
- Serves hits in the lookup cycle.
- On a miss, writes back a dirty victim word by word over the memory bus, refills the line, then replays the lookup.
- Sits between the CPU data port, the set lookup/replacement stage and the memory bus.

---
 rtl/cache_miss_ctrl.sv | 151 +++++++++++++++
 tb/tb_cache_miss_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/cache_miss_ctrl.sv
// Per-access miss controller for the set-associative data cache: zero-wait hits,
// dirty-victim writeback, line refill and replay of the original lookup.
module cache_miss_ctrl #(
  parameter int TAG_WIDTH    = 26,
  parameter int INDEX_WIDTH  = 2,
  parameter int OFFSET_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cpu_req,
  input  logic                    cpu_wen,
  input  logic [31:0]             cpu_addr,
  input  logic [31:0]             cpu_wdata,
  output logic                    cpu_ready,
  output logic [31:0]             cpu_rdata,
  input  logic                    lk_hit,
  input  logic                    lk_dirty,
  input  logic [TAG_WIDTH-1:0]    lk_replace_tag,
  input  logic [31:0]             lk_read_data,
  output logic [OFFSET_WIDTH-3:0] lk_offset,
  output logic                    lk_en,
  output logic                    lk_wen,
  output logic                    fill_we,
  output logic [31:0]             fill_data,
  output logic                    fill_done,
  output logic                    mem_req,
  output logic                    mem_wen,
  output logic [31:0]             mem_addr,
  output logic [31:0]             mem_wdata,
  input  logic [31:0]             mem_rdata,
  input  logic                    mem_ready
);

  localparam int WORD_BITS = OFFSET_WIDTH - 2;
  localparam int LINE_BITS = TAG_WIDTH + INDEX_WIDTH;
  localparam logic [WORD_BITS-1:0] CNT_LAST = {WORD_BITS{1'b1}};
  localparam logic [WORD_BITS-1:0] CNT_ONE  = {{(WORD_BITS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    LOOKUP    = 2'd0,
    WRITEBACK = 2'd1,
    REFILL    = 2'd2,
    FINISH    = 2'd3
  } state_t;

  state_t                 state, state_next;
  logic [WORD_BITS-1:0]   cnt, cnt_next;
  logic [LINE_BITS-1:0]   addr_q, addr_next;   // {tag, index} of the missing access
  logic [TAG_WIDTH-1:0]   vtag_q, vtag_next;

  // Store data goes straight to the data array; only the line address bits are kept here.
  logic unused_bits;
  assign unused_bits = ^{cpu_wdata, cpu_addr[1:0]};

  // State, word counter and latched miss context.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= LOOKUP;
      cnt    <= {WORD_BITS{1'b0}};
      addr_q <= {LINE_BITS{1'b0}};
      vtag_q <= {TAG_WIDTH{1'b0}};
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      addr_q <= addr_next;
      vtag_q <= vtag_next;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    addr_next  = addr_q;
    vtag_next  = vtag_q;
    cpu_ready  = 1'b0;
    cpu_rdata  = 32'h0000_0000;
    lk_offset  = cpu_addr[OFFSET_WIDTH-1:2];
    lk_en      = 1'b0;
    lk_wen     = 1'b0;
    fill_we    = 1'b0;
    fill_data  = 32'h0000_0000;
    fill_done  = 1'b0;
    mem_req    = 1'b0;
    mem_wen    = 1'b0;
    mem_addr   = 32'h0000_0000;
    mem_wdata  = 32'h0000_0000;
    case (state)
      LOOKUP: begin
        if (cpu_req && lk_hit) begin
          cpu_ready = 1'b1;
          cpu_rdata = lk_read_data;
          lk_wen    = cpu_wen;
        end else if (cpu_req) begin
          addr_next  = cpu_addr[31:OFFSET_WIDTH];
          vtag_next  = lk_replace_tag;
          cnt_next   = {WORD_BITS{1'b0}};
          state_next = lk_dirty ? WRITEBACK : REFILL;
        end else begin
          state_next = LOOKUP;
        end
      end
      WRITEBACK: begin
        lk_offset = cnt;
        mem_req   = 1'b1;
        mem_wen   = 1'b1;
        mem_addr  = {vtag_q, addr_q[INDEX_WIDTH-1:0], cnt, 2'b00};
        mem_wdata = lk_read_data;
        if (mem_ready) begin
          cnt_next = cnt + CNT_ONE;
          if (cnt == CNT_LAST) begin
            state_next = REFILL;
          end else begin
            state_next = WRITEBACK;
          end
        end else begin
          cnt_next = cnt;
        end
      end
      REFILL: begin
        // Read buffers upstream are not assumed; the word is written into the way as it arrives.
        lk_offset = cnt;
        mem_req   = 1'b1;
        mem_addr  = {addr_q, cnt, 2'b00};
        fill_data = mem_rdata;
        if (mem_ready) begin
          fill_we  = 1'b1;
          cnt_next = cnt + CNT_ONE;
          if (cnt == CNT_LAST) begin
            state_next = FINISH;
          end else begin
            state_next = REFILL;
          end
        end else begin
          cnt_next = cnt;
        end
      end
      FINISH: begin
        fill_done  = 1'b1;
        lk_en      = 1'b1;
        cnt_next   = {WORD_BITS{1'b0}};
        state_next = LOOKUP;
      end
      default: begin
        cnt_next   = {WORD_BITS{1'b0}};
        state_next = LOOKUP;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Self-checking bench for cache_miss_ctrl: table-driven lookup vectors plus
// scoreboarded miss sequences (clean, dirty, stalled, reset mid-refill).
module tb_cache_miss_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0, cpu_wen = 1'b0;
  logic [31:0] cpu_addr = 32'h0, cpu_wdata = 32'h0;
  logic        cpu_ready;
  logic [31:0] cpu_rdata;
  logic        lk_hit = 1'b0, lk_dirty = 1'b0;
  logic [25:0] lk_replace_tag = 26'h0;
  logic [31:0] lk_read_data;
  logic [1:0]  lk_offset;
  logic        lk_en, lk_wen, fill_we, fill_done;
  logic [31:0] fill_data;
  logic        mem_req, mem_wen, mem_ready = 1'b0;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic        lk_mode = 1'b0;          // 1: lookup returns victim line words by lk_offset
  logic [31:0] lk_read_val = 32'h0;

  assign lk_read_data = lk_mode ? (32'hB000_0000 + {30'd0, lk_offset}) : lk_read_val;
  assign mem_rdata    = 32'h0000_00A0 + {30'd0, mem_addr[3:2]};

  always #5 clk = ~clk;

  cache_miss_ctrl dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
    .lk_hit(lk_hit), .lk_dirty(lk_dirty), .lk_replace_tag(lk_replace_tag),
    .lk_read_data(lk_read_data), .lk_offset(lk_offset), .lk_en(lk_en), .lk_wen(lk_wen),
    .fill_we(fill_we), .fill_data(fill_data), .fill_done(fill_done),
    .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  int checks = 0;
  int failures = 0;
  int fd_total = 0;

  typedef struct { logic wen; logic [31:0] addr; logic [31:0] data; } mem_txn_t;
  typedef struct { logic [1:0] off; logic [31:0] data; } fill_txn_t;
  mem_txn_t  exp_q[$];
  fill_txn_t fill_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Memory/fill scoreboard and handshake-stability monitor.
  logic        prev_wait = 1'b0;
  logic        prev_wen;
  logic [31:0] prev_addr, prev_wdata;
  always @(negedge clk) begin
    if (reset) begin
      prev_wait = 1'b0;
    end else begin
      if (prev_wait && mem_req) begin
        check("hold_addr", mem_addr, prev_addr);
        check("hold_wen", {31'd0, mem_wen}, {31'd0, prev_wen});
        check("hold_wdata", mem_wdata, prev_wdata);
      end
      if (mem_req && mem_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_mem_xfer", mem_addr, 32'hFFFF_FFFF);
        end else begin
          mem_txn_t t;
          t = exp_q.pop_front();
          check("mem_wen", {31'd0, mem_wen}, {31'd0, t.wen});
          check("mem_addr", mem_addr, t.addr);
          if (t.wen) check("mem_wdata", mem_wdata, t.data);
        end
      end
      if (fill_we) begin
        if (fill_q.size() == 0) begin
          check("unexpected_fill", fill_data, 32'hFFFF_FFFF);
        end else begin
          fill_txn_t f;
          f = fill_q.pop_front();
          check("fill_offset", {30'd0, lk_offset}, {30'd0, f.off});
          check("fill_data", fill_data, f.data);
        end
      end
      if (fill_done) fd_total++;
      prev_wait  = mem_req && !mem_ready;
      prev_addr  = mem_addr;
      prev_wen   = mem_wen;
      prev_wdata = mem_wdata;
    end
  end

  // One miss from request to replayed hit, with gap idle cycles before each mem_ready.
  task automatic run_miss(input logic [31:0] addr, input logic dirty, input logic [25:0] vtag,
                          input int gap, input int exp_cycles);
    int cycles = 0, wait_cnt = 0, fd_start;
    logic fd_seen = 1'b0, done = 1'b0;
    logic [31:0] idx_bits;
    idx_bits = (addr >> 4) & 32'h3;
    for (int i = 0; i < 4; i++) begin
      if (dirty) exp_q.push_back('{1'b1, ({6'd0, vtag} << 6) | (idx_bits << 4) | (i << 2),
                                   32'hB000_0000 + i});
    end
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back('{1'b0, (addr & 32'hFFFF_FFF0) + 32'(i * 4), 32'h0});
      fill_q.push_back('{i[1:0], 32'h0000_00A0 + i});
    end
    fd_start = fd_total;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_wen = 1'b0; cpu_addr = addr; lk_hit = 1'b0;
    lk_dirty = dirty; lk_replace_tag = vtag; lk_mode = 1'b1; mem_ready = 1'b0;
    while (!done && cycles < 400) begin
      @(negedge clk);
      if (cpu_ready) begin
        done = 1'b1;
        check("replay_rdata", cpu_rdata, 32'h0000_00A0 + ((addr >> 2) & 32'h3));
        check("miss_latency", cycles, exp_cycles);
      end
      if (fill_done) begin
        check("finish_lk_en", {31'd0, lk_en}, 32'd1);
        fd_seen = 1'b1;
      end
      @(posedge clk); #1;
      cycles++;
      if (fd_seen) begin
        lk_hit = 1'b1; lk_mode = 1'b0;
        lk_read_val = 32'h0000_00A0 + ((addr >> 2) & 32'h3);
      end
      if (mem_req) begin
        if (wait_cnt >= gap) begin mem_ready = 1'b1; wait_cnt = 0; end
        else begin mem_ready = 1'b0; wait_cnt++; end
      end else begin
        mem_ready = 1'b0;
      end
    end
    if (!done) check("miss_timeout", 32'd0, 32'd1);
    check("fill_done_count", fd_total - fd_start, 32'd1);
    check("mem_q_drained", exp_q.size(), 32'd0);
    check("fill_q_drained", fill_q.size(), 32'd0);
    cpu_req = 1'b0; lk_hit = 1'b0; lk_dirty = 1'b0; mem_ready = 1'b0;
    exp_q.delete(); fill_q.delete();
  endtask

  typedef struct {
    logic req; logic wen; logic [31:0] addr; logic [31:0] wdata; logic hit;
    logic [31:0] rd; logic mrdy;
    logic e_ready; logic [31:0] e_rdata; logic e_lkwen; logic [1:0] e_off;
  } vec_t;
  vec_t vecs[6];

  initial begin
    int fd_before;
    vecs[0] = '{1'b0, 1'b0, 32'h0000_0044, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 2'd1};
    vecs[1] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 2'd0};
    vecs[2] = '{1'b1, 1'b1, 32'h0000_0080, 32'h11, 1'b1, 32'h1234_5678, 1'b0, 1'b1, 32'h1234_5678, 1'b1, 2'd0};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_004C, 32'h0, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b1, 32'hCAFE_F00D, 1'b0, 2'd3};
    vecs[4] = '{1'b0, 1'b1, 32'h0000_0088, 32'h22, 1'b1, 32'h5555_AAAA, 1'b1, 1'b0, 32'h0, 1'b0, 2'd2};
    vecs[5] = '{1'b1, 1'b1, 32'h0000_0088, 32'h33, 1'b1, 32'h0BAD_F00D, 1'b1, 1'b1, 32'h0BAD_F00D, 1'b1, 2'd2};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_cpu_ready", {31'd0, cpu_ready}, 32'd0);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_ctrl", {27'd0, lk_en, lk_wen, fill_we, fill_done, mem_wen}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    reset = 1'b0;

    // Lookup-cycle vectors: hits, idle, and stray mem_ready.
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      cpu_req = vecs[i].req; cpu_wen = vecs[i].wen; cpu_addr = vecs[i].addr;
      cpu_wdata = vecs[i].wdata; lk_hit = vecs[i].hit; lk_read_val = vecs[i].rd;
      mem_ready = vecs[i].mrdy;
      @(negedge clk);
      check($sformatf("v%0d_cpu_ready", i), {31'd0, cpu_ready}, {31'd0, vecs[i].e_ready});
      if (vecs[i].e_ready) check($sformatf("v%0d_cpu_rdata", i), cpu_rdata, vecs[i].e_rdata);
      check($sformatf("v%0d_lk_wen", i), {31'd0, lk_wen}, {31'd0, vecs[i].e_lkwen});
      check($sformatf("v%0d_lk_offset", i), {30'd0, lk_offset}, {30'd0, vecs[i].e_off});
      check($sformatf("v%0d_quiet", i), {28'd0, lk_en, fill_we, fill_done, mem_req}, 32'd0);
    end
    @(posedge clk); #1;
    cpu_req = 1'b0; lk_hit = 1'b0; mem_ready = 1'b0;

    run_miss(32'h0000_1230, 1'b0, 26'h0, 0, 6);
    run_miss(32'h0000_2014, 1'b1, 26'h5, 0, 10);
    run_miss(32'h0000_3344, 1'b1, 26'h2A, 3, 34);

    // Reset asserted during the second refill word.
    fd_before = fd_total;
    exp_q.push_back('{1'b0, 32'h0000_1230, 32'h0});
    fill_q.push_back('{2'd0, 32'h0000_00A0});
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_addr = 32'h0000_1230; lk_hit = 1'b0; lk_dirty = 1'b0; lk_mode = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    check("pre_rst_mem_req", {31'd0, mem_req}, 32'd1);
    check("pre_rst_mem_addr", mem_addr, 32'h0000_1234);
    #1 reset = 1'b1;
    #1;
    check("midrst_mem_req", {31'd0, mem_req}, 32'd0);
    check("midrst_fill", {30'd0, fill_we, fill_done}, 32'd0);
    cpu_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("postrst_idle", {28'd0, mem_req, cpu_ready, lk_en, fill_done}, 32'd0);
    check("postrst_no_fill_done", fd_total - fd_before, 32'd0);
    check("postrst_q_drained", exp_q.size() + fill_q.size(), 32'd0);
    exp_q.delete(); fill_q.delete();
    run_miss(32'h0000_1230, 1'b0, 26'h0, 0, 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
